// File: rtl/mod_6432_pkg.sv
// Shared widths and FSM encoding for the RSA modular-reduction datapath.
package rsa_pkg;
    localparam int DW = 64;
    localparam int MW = 32;
    localparam int CW = $clog2(DW);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/mod_6432_step.sv
// One restoring shift-subtract step: shift a dividend bit into the
// remainder and subtract the modulus when it fits.
module mod_step
    import rsa_pkg::*;
(
    input  logic [MW-1:0] rem,
    input  logic          bit_in,
    input  logic [MW-1:0] mreg,
    output logic [MW-1:0] next_rem
);
    logic [MW:0] t;
    logic        ge;

    // rem < mreg keeps t below 2*mreg, so the low MW bits of t - mreg
    // hold the exact difference whenever ge is set.
    always_comb begin
        t        = {rem, bit_in};
        ge       = (t >= {1'b0, mreg});
        next_rem = ge ? (t[MW-1:0] - mreg) : t[MW-1:0];
    end
endmodule

// File: rtl/mod_6432.sv
// Iterative 64-by-32 modular reducer: result = dividend mod modulus,
// one dividend bit per cycle, fixed 64-cycle latency.
module mod_6432
    import rsa_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [MW-1:0] modulus,
    output logic [MW-1:0] result,
    output logic          ready_n,
    output logic          busy,
    output logic          err
);
    localparam logic [CW-1:0] LAST = CW'(DW - 1);

    logic [1:0]    state;
    logic [1:0]    nstate;
    logic [DW-1:0] dreg;
    logic [MW-1:0] mreg;
    logic [MW-1:0] rem;
    logic [MW-1:0] nrem;
    logic [CW-1:0] count;

    mod_step u_step (
        .rem      (rem),
        .bit_in   (dreg[DW-1]),
        .mreg     (mreg),
        .next_rem (nrem)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= nstate;
    end

    always_comb begin
        nstate = state;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (start)
                    nstate = (modulus == '0) ? ST_DONE : ST_CALC;
            end
            ST_CALC: begin
                if (count == LAST) nstate = ST_DONE;
            end
            default: nstate = ST_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state == ST_CALC);
        ready_n = (state != ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dreg   <= '0;
            mreg   <= '0;
            rem    <= '0;
            count  <= '0;
            result <= '0;
            err    <= 1'b0;
        end else if (state == ST_CALC) begin
            rem   <= nrem;
            dreg  <= dreg << 1;
            count <= count + 1'b1;
            if (count == LAST) result <= nrem;
        end else if (start) begin
            // A zero modulus is flagged without entering CALC.
            if (modulus == '0) begin
                err    <= 1'b1;
                result <= '0;
            end else begin
                dreg  <= dividend;
                mreg  <= modulus;
                rem   <= '0;
                count <= '0;
                err   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mod_6432.sv
// Self-checking bench for mod_6432 against a plain a % n reference.
module tb_mod_6432;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] dividend = '0;
    logic [31:0] modulus = '0;
    logic [31:0] result;
    logic        ready_n;
    logic        busy;
    logic        err;

    int n_checks = 0;
    int n_fail = 0;

    mod_6432 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .dividend (dividend),
        .modulus  (modulus),
        .result   (result),
        .ready_n  (ready_n),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_mod(logic [63:0] d, logic [31:0] m);
        logic [63:0] r;
        r = d % {32'd0, m};
        return r[31:0];
    endfunction

    // Pulse start for one edge, then scramble the operand inputs.
    task automatic issue(input logic [63:0] d, input logic [31:0] m);
        @(negedge clk);
        dividend = d;
        modulus  = m;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = {$urandom, $urandom};
        modulus  = $urandom;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (ready_n === 1'b1 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks += 4;
        if (result !== 32'd0) begin
            n_fail++; $display("FAIL reset_result got=%h exp=0", result);
        end
        if (ready_n !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready_n got=%b exp=1", ready_n);
        end
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy got=%b exp=0", busy);
        end
        if (err !== 1'b0) begin
            n_fail++; $display("FAIL reset_err got=%b exp=0", err);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_vectors;
        logic [63:0] ds [5];
        logic [31:0] ms [5];
        logic [31:0] ex [5];
        int cyc;
        ds = '{64'd100, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFE_0000_0001, 64'd5};
        ms = '{32'd7, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFB, 32'd9};
        ex = '{32'd2, 32'd0, 32'd0, 32'h10, 32'd5};
        for (int i = 0; i < 5; i++) begin
            issue(ds[i], ms[i]);
            n_checks += 2;
            if (busy !== 1'b1) begin
                n_fail++; $display("FAIL vec%0d_busy got=%b exp=1", i, busy);
            end
            if (ready_n !== 1'b1) begin
                n_fail++; $display("FAIL vec%0d_ready_n got=%b exp=1", i, ready_n);
            end
            wait_done(cyc);
            n_checks += 5;
            if (cyc != 64) begin
                n_fail++; $display("FAIL vec%0d_latency got=%0d exp=64", i, cyc);
            end
            if (result !== ex[i]) begin
                n_fail++; $display("FAIL vec%0d_result got=%h exp=%h", i, result, ex[i]);
            end
            if (result !== ref_mod(ds[i], ms[i])) begin
                n_fail++; $display("FAIL vec%0d_model got=%h exp=%h", i, result, ref_mod(ds[i], ms[i]));
            end
            if (busy !== 1'b0) begin
                n_fail++; $display("FAIL vec%0d_done_busy got=%b exp=0", i, busy);
            end
            if (err !== 1'b0) begin
                n_fail++; $display("FAIL vec%0d_err got=%b exp=0", i, err);
            end
        end
    endtask

    task automatic test_random;
        logic [63:0] d;
        logic [31:0] m;
        logic [31:0] exp_r;
        int cyc;
        for (int i = 0; i < 20; i++) begin
            d = {$urandom, $urandom};
            m = $urandom;
            if (i % 4 == 1) m = m >> $urandom_range(31, 16);
            if (i % 5 == 2) d = d >> $urandom_range(63, 40);
            if (m == 32'd0) m = 32'd3;
            exp_r = ref_mod(d, m);
            issue(d, m);
            wait_done(cyc);
            n_checks += 2;
            if (cyc != 64) begin
                n_fail++; $display("FAIL rand%0d_latency got=%0d exp=64", i, cyc);
            end
            if (result !== exp_r) begin
                n_fail++; $display("FAIL rand%0d_result d=%h m=%h got=%h exp=%h", i, d, m, result, exp_r);
            end
        end
    endtask

    task automatic test_zero_mod;
        int cyc;
        issue(64'd123, 32'd0);
        n_checks += 4;
        if (err !== 1'b1) begin
            n_fail++; $display("FAIL zero_err got=%b exp=1", err);
        end
        if (result !== 32'd0) begin
            n_fail++; $display("FAIL zero_result got=%h exp=0", result);
        end
        if (ready_n !== 1'b0) begin
            n_fail++; $display("FAIL zero_ready_n got=%b exp=0", ready_n);
        end
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL zero_busy got=%b exp=0", busy);
        end
        issue(64'd1000, 32'd13);
        n_checks += 2;
        if (err !== 1'b0) begin
            n_fail++; $display("FAIL zero_clear_err got=%b exp=0", err);
        end
        if (ready_n !== 1'b1) begin
            n_fail++; $display("FAIL zero_clear_ready_n got=%b exp=1", ready_n);
        end
        wait_done(cyc);
        n_checks += 2;
        if (cyc != 64) begin
            n_fail++; $display("FAIL zero_next_latency got=%0d exp=64", cyc);
        end
        if (result !== ref_mod(64'd1000, 32'd13)) begin
            n_fail++; $display("FAIL zero_next_result got=%h exp=%h", result, ref_mod(64'd1000, 32'd13));
        end
    endtask

    task automatic test_ignore_start;
        int cyc;
        issue(64'd100, 32'd7);
        repeat (9) @(posedge clk);
        @(negedge clk);
        dividend = 64'd50;
        modulus  = 32'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(cyc);
        n_checks += 2;
        if (cyc != 54) begin
            n_fail++; $display("FAIL ignore_latency got=%0d exp=54", cyc);
        end
        if (result !== 32'd2) begin
            n_fail++; $display("FAIL ignore_result got=%h exp=2", result);
        end
    endtask

    task automatic test_abort;
        int cyc;
        issue(64'hDEAD_BEEF_1234_5678, 32'h0001_0001);
        repeat (29) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_checks += 4;
        if (result !== 32'd0) begin
            n_fail++; $display("FAIL abort_result got=%h exp=0", result);
        end
        if (ready_n !== 1'b1) begin
            n_fail++; $display("FAIL abort_ready_n got=%b exp=1", ready_n);
        end
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_busy got=%b exp=0", busy);
        end
        if (err !== 1'b0) begin
            n_fail++; $display("FAIL abort_err got=%b exp=0", err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        issue(64'd987654321, 32'd1000);
        wait_done(cyc);
        n_checks += 2;
        if (cyc != 64) begin
            n_fail++; $display("FAIL abort_fresh_latency got=%0d exp=64", cyc);
        end
        if (result !== 32'd321) begin
            n_fail++; $display("FAIL abort_fresh_result got=%h exp=%h", result, 32'd321);
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        logic [63:0] d;
        logic [31:0] m;
        d = {$urandom, $urandom};
        m = $urandom | 32'h8000_0000;
        issue(d, m);
        n_checks += 3;
        if (ready_n !== 1'b1) begin
            n_fail++; $display("FAIL b2b_ready_n got=%b exp=1", ready_n);
        end
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL b2b_busy got=%b exp=1", busy);
        end
        wait_done(cyc);
        if (cyc != 64) begin
            n_fail++; $display("FAIL b2b_latency got=%0d exp=64", cyc);
        end
        n_checks += 1;
        if (result !== ref_mod(d, m)) begin
            n_fail++; $display("FAIL b2b_result got=%h exp=%h", result, ref_mod(d, m));
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_random();
        test_zero_mod();
        test_ignore_start();
        test_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
